axis_byte_packer: RTL
=====================

AXIS_BYTE_PACKER -- requirements
Module: axis_byte_packer

Interface
REQ-001 The block SHALL take these parameters, one per line: name, default, meaning.
- BYTES_PER_WORD, 4, output word width in bytes; only 4 is supported.
- PAD_BYTE, 8'h00, value written into unused byte lanes of a partial final word.
- CNT_W, 16, width of frame_count.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- ACLK, in, 1, the single clock; all logic on its rising edge.
- ARESETN, in, 1, reset; synchronous and active-low.
- s_axis_tdata, in, 8, input byte.
- s_axis_tvalid, in, 1, input byte valid.
- s_axis_tready, out, 1, input byte accepted.
- s_axis_tlast, in, 1, input byte is the last byte of its frame.
- m_axis_tdata, out, 32, packed word; drives the downstream 32-bit stream stage.
- m_axis_tkeep, out, 4, valid-byte mask.
- m_axis_tvalid, out, 1, output word valid.
- m_axis_tready, in, 1, downstream ready.
- m_axis_tlast, out, 1, word ends a frame.
- frame_count, out, CNT_W, count of output words sent with tlast; wraps.

Function
REQ-003 The input byte SHALL transfer when s_axis_tvalid&&s_axis_tready at a rising ACLK edge; the output word SHALL transfer when m_axis_tvalid&&m_axis_tready.
REQ-004 Byte order SHALL be little-endian: the first byte of a word goes to lane [7:0], and the fourth byte goes to lane [31:24].
REQ-005 The block SHALL contain an accumulator (lane index 0..3 plus byte registers) and an output register (tdata, tkeep, tlast, and a valid flag).
REQ-006 The accumulator state machine SHALL have two states.
- FILL: bytes are accepted.
- HOLD: a completed word is waiting because the output register is occupied.
REQ-007 s_axis_tready SHALL equal (state==FILL) and SHALL have no combinational dependence on m_axis_tready, s_axis_tvalid or s_axis_tlast.
REQ-008 A word SHALL complete when an accepted byte lands in lane 3, or when an accepted byte has s_axis_tlast=1; in either case the lane index SHALL return to 0.
REQ-009 On completion, if the output register is empty or drains in the same cycle, the completed word SHALL load into the output register at that same edge, giving one cycle of latency from the completing byte to m_axis_tvalid=1.
REQ-010 On completion, if the output register is occupied and not draining, the word SHALL stay in the accumulator and the state SHALL go to HOLD.
REQ-011 In HOLD, on the edge where the output drains, the held word SHALL move into the output register and the state SHALL return to FILL; s_axis_tready rises in the following cycle.
REQ-012 For a partial final word, unused lanes SHALL be PAD_BYTE and m_axis_tkeep SHALL be the contiguous low mask for the lanes used.
- 1 byte gives 0001; 2 bytes give 0011; 3 bytes give 0111.
- A full word gives 1111.
REQ-013 m_axis_tdata, m_axis_tkeep and m_axis_tlast SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-014 With m_axis_tready held at 1, the block SHALL sustain one input byte per cycle with no bubbles.
REQ-015 frame_count SHALL increment by 1 on each output transfer with m_axis_tlast=1, and SHALL wrap from all-ones to 0.
REQ-016 The block SHALL never drop or duplicate a byte under any tvalid/tready pattern.

Reset
REQ-017 While ARESETN=0 at an edge, the block SHALL reset to:
- state = FILL, lane index = 0;
- m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tkeep = 0, m_axis_tlast = 0;
- frame_count = 0.
REQ-018 While ARESETN=0, s_axis_tready SHALL be 0.
REQ-019 A reset in the middle of a frame SHALL discard the partial accumulator and any pending output word without emitting them; the first byte after reset SHALL go to lane 0.

Structure
REQ-020 BYTES_PER_WORD, the tkeep-mask function and the FILL/HOLD state enum SHALL live in the shared stream package.
REQ-021 The block SHALL be a single module with no sub-modules; the output register is inline.

Verification
REQ-022 The bench SHALL cover these directed scenarios.
- Bytes 00,ff,00,ff (tlast on the 4th) -> one word 0xff00ff00, tkeep 1111, tlast 1, frame_count 1.
- Bytes 11,22,33 (tlast on 33) -> word 0x00332211, tkeep 0111, tlast 1; with PAD_BYTE=8'hAA the word is 0xAA332211.
- Single byte 5A with tlast -> word 0x0000005A, tkeep 0001.
- 16 bytes 00..0f back-to-back with m_axis_tready=1 -> s_axis_tready stays 1 throughout; words 0x03020100 .. 0x0f0e0d0c appear 1 cycle after each 4th byte.
- 12 bytes sent with m_axis_tready=0 for 10 cycles -> s_axis_tready drops after the 8th byte; after release the 3 words arrive in order with no loss.
- Reset asserted after 2 bytes of a frame -> no output; after release, bytes 01,02,03,04 with tlast give 0x04030201 and frame_count 1.

Source files
------------

// File: rtl/axis_byte_packer_pkg.sv
// Shared stream definitions for the byte packer: word geometry, accumulator
// state encoding and the byte-lane keep mask.
package axis_byte_packer_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_e;

    // Contiguous low mask covering lanes 0..last_lane.
    function automatic logic [BYTES_PER_WORD-1:0] keep_mask(input logic [1:0] last_lane);
        keep_mask = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (2'(i) <= last_lane) keep_mask[i] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/axis_byte_packer_if.sv
// Byte-in / word-out stream bundle of the byte packer.
// Handshake: a beat transfers on a rising clock edge where tvalid && tready;
// a source holds tvalid and its payload stable until that transfer happens.
interface axis_byte_packer_if;

    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
    );

endinterface

// File: rtl/axis_byte_packer.sv
// Packs an 8-bit byte stream into little-endian 32-bit words with tkeep/tlast,
// padding short final words and counting completed frames.
module axis_byte_packer
    import axis_byte_packer_pkg::pack_state_e, axis_byte_packer_pkg::FILL,
           axis_byte_packer_pkg::HOLD, axis_byte_packer_pkg::keep_mask;
#(
    parameter int         BYTES_PER_WORD = axis_byte_packer_pkg::BYTES_PER_WORD,
    parameter logic [7:0] PAD_BYTE       = 8'h00,
    parameter int         CNT_W          = 16
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    axis_byte_packer_if.slave bus,
    output logic [CNT_W-1:0]  frame_count
);

    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    typedef logic [BYTES_PER_WORD-1:0][7:0] word_t;

    pack_state_e               state_q;
    logic [1:0]                lane_q;
    word_t                     acc_q;
    word_t                     hold_data_q;
    logic [BYTES_PER_WORD-1:0] hold_keep_q;
    logic                      hold_last_q;
    word_t                     m_data_q;
    logic [BYTES_PER_WORD-1:0] m_keep_q;
    logic                      m_last_q;
    logic                      m_valid_q;
    logic [CNT_W-1:0]          frame_cnt_q;

    logic                      s_ready;
    logic                      accept;
    logic                      complete;
    logic                      out_drain;
    logic                      out_free;
    word_t                     word_d;
    logic [BYTES_PER_WORD-1:0] keep_d;

    // Ready depends only on registered state, so the upstream never sees a
    // combinational path from the downstream ready.
    assign s_ready   = ARESETN && (state_q == FILL);
    assign accept    = s_ready && bus.s_axis_tvalid;
    assign complete  = accept && ((lane_q == LAST_LANE) || bus.s_axis_tlast);
    assign out_drain = m_valid_q && bus.m_axis_tready;
    assign out_free  = !m_valid_q || out_drain;
    assign keep_d    = keep_mask(lane_q);

    always_comb begin
        word_d = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (2'(i) < lane_q)       word_d[i] = acc_q[i];
            else if (2'(i) == lane_q) word_d[i] = bus.s_axis_tdata;
            else                      word_d[i] = PAD_BYTE;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q     <= FILL;
            lane_q      <= '0;
            acc_q       <= '0;
            hold_data_q <= '0;
            hold_keep_q <= '0;
            hold_last_q <= 1'b0;
            m_data_q    <= '0;
            m_keep_q    <= '0;
            m_last_q    <= 1'b0;
            m_valid_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (out_drain) begin
                m_valid_q <= 1'b0;
                if (m_last_q) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
            case (state_q)
                FILL: begin
                    if (accept) begin
                        acc_q[lane_q] <= bus.s_axis_tdata;
                        lane_q        <= complete ? 2'd0 : lane_q + 2'd1;
                        if (complete && out_free) begin
                            m_data_q  <= word_d;
                            m_keep_q  <= keep_d;
                            m_last_q  <= bus.s_axis_tlast;
                            m_valid_q <= 1'b1;
                        end else if (complete) begin
                            hold_data_q <= word_d;
                            hold_keep_q <= keep_d;
                            hold_last_q <= bus.s_axis_tlast;
                            state_q     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_drain) begin
                        m_data_q  <= hold_data_q;
                        m_keep_q  <= hold_keep_q;
                        m_last_q  <= hold_last_q;
                        m_valid_q <= 1'b1;
                        state_q   <= FILL;
                    end
                end
            endcase
        end
    end

    assign bus.s_axis_tready = s_ready;
    assign bus.m_axis_tdata  = m_data_q;
    assign bus.m_axis_tkeep  = m_keep_q;
    assign bus.m_axis_tlast  = m_last_q;
    assign bus.m_axis_tvalid = m_valid_q;
    assign frame_count       = frame_cnt_q;

endmodule
